// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the five-stage pipeline control path.
//   regbits_t   : 5-bit architectural register index
//   seq_state_t : pipeline_sequencer FSM state
//   seq_ctrl_t  : bundle of PC enable and pipeline-latch enable/flush controls
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic pcWEN;
        logic ifidW;
        logic ifidRST;
        logic idexW;
        logic idexRST;
        logic exmemW;
        logic exmemRST;
        logic memW;
        logic memRST;
    } seq_ctrl_t;

    // Everything frozen: no PC update, no latch written.
    localparam seq_ctrl_t CTRL_FREEZE = '0;

    // Normal flow: every latch and the PC advance, nothing flushed.
    localparam seq_ctrl_t CTRL_ADVANCE = '{
        pcWEN: 1'b1, ifidW: 1'b1, ifidRST: 1'b0, idexW: 1'b1, idexRST: 1'b0,
        exmemW: 1'b1, exmemRST: 1'b0, memW: 1'b1, memRST: 1'b0
    };

    // Reset: write a flush into every latch, hold the PC.
    localparam seq_ctrl_t CTRL_RESET = '{
        pcWEN: 1'b0, ifidW: 1'b1, ifidRST: 1'b1, idexW: 1'b1, idexRST: 1'b1,
        exmemW: 1'b1, exmemRST: 1'b1, memW: 1'b1, memRST: 1'b1
    };

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Flags a load in EX whose destination is read by the instruction in ID.
// Ports:
//   idexMemRead in  : EX-stage instruction is a load
//   idexrt      in  : load destination register
//   ifidrs      in  : ID-stage source register rs
//   ifidrt      in  : ID-stage source register rt
//   lu          out : load-use hazard present this cycle
// -----------------------------------------------------------------------------
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     idexMemRead,
    input  regbits_t idexrt,
    input  regbits_t ifidrs,
    input  regbits_t ifidrt,
    output logic     lu
);

    // Register 0 is hardwired to zero, so a load targeting it never creates
    // a real dependency.
    assign lu = idexMemRead && (idexrt != '0) &&
                ((idexrt == ifidrs) || (idexrt == ifidrt));

endmodule

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
// Central stall/flush controller for the five-stage pipeline. Drives the PC
// write enable and the write-enable/flush pair of each pipeline latch,
// sequences data-cache waits and the halt drain, and counts stall cycles.
// Ports:
//   CLK, RST            in  : clock, synchronous active-high reset
//   ihit, dhit          in  : instruction / data access completed this cycle
//   memdREN, memdWEN    in  : MEM-stage instruction reads / writes memory
//   memcuHALT           in  : MEM-stage instruction is HALT
//   idexMemRead, idexrt in  : EX-stage load and its destination
//   ifidrs, ifidrt      in  : ID-stage source registers
//   exPCSrc             in  : taken branch/jump resolved in EX
//   pcWEN               out : PC update enable
//   ifidW/ifidRST .. memW/memRST out : per-latch enable and flush
//   halt                out : sticky, registered, core halted
//   stall_count         out : saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module pipeline_sequencer
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memdREN,
    input  logic             memdWEN,
    input  logic             memcuHALT,
    input  logic             idexMemRead,
    input  logic [4:0]       idexrt,
    input  logic [4:0]       ifidrs,
    input  logic [4:0]       ifidrt,
    input  logic             exPCSrc,
    output logic             pcWEN,
    output logic             ifidW,
    output logic             ifidRST,
    output logic             idexW,
    output logic             idexRST,
    output logic             exmemW,
    output logic             exmemRST,
    output logic             memW,
    output logic             memRST,
    output logic             halt,
    output logic [CNT_W-1:0] stall_count
);

    seq_state_t state, next_state;
    seq_ctrl_t  ctrl;
    logic       lu;
    logic       dstall;
    logic       freeze;
    logic       count_en;

    load_use_detect u_lu (
        .idexMemRead (idexMemRead),
        .idexrt      (idexrt),
        .ifidrs      (ifidrs),
        .ifidrt      (ifidrt),
        .lu          (lu)
    );

    assign dstall = (memdREN || memdWEN) && !dhit;

    // In DWAIT the access is already known to be outstanding, so only dhit
    // matters; in RUN a new miss is detected from the MEM-stage request.
    assign freeze = (state == DWAIT) ? !dhit : dstall;

    // NOTE: every signal written in always_comb gets a default first so that
    // no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        next_state = state;
        ctrl       = CTRL_FREEZE;
        if (RST) begin
            ctrl = CTRL_RESET;
        end else begin
            unique case (state)
                RUN, DWAIT: begin
                    next_state = RUN;
                    if (freeze) begin
                        next_state = DWAIT;
                    end else if (memcuHALT) begin
                        // HALT moves into MEM/WB; everything younger is killed.
                        ctrl          = CTRL_ADVANCE;
                        ctrl.pcWEN    = 1'b0;
                        ctrl.ifidRST  = 1'b1;
                        ctrl.idexRST  = 1'b1;
                        ctrl.exmemRST = 1'b1;
                        next_state    = DRAIN;
                    end else if (exPCSrc) begin
                        // Branch wins over a pending load-use or fetch miss:
                        // both wrong-path instructions are flushed anyway.
                        ctrl         = CTRL_ADVANCE;
                        ctrl.ifidRST = 1'b1;
                        ctrl.idexRST = 1'b1;
                    end else if (lu) begin
                        ctrl         = CTRL_ADVANCE;
                        ctrl.pcWEN   = 1'b0;
                        ctrl.ifidW   = 1'b0;
                        ctrl.idexRST = 1'b1;
                    end else if (!ihit) begin
                        ctrl         = CTRL_ADVANCE;
                        ctrl.pcWEN   = 1'b0;
                        ctrl.ifidRST = 1'b1;
                    end else begin
                        ctrl = CTRL_ADVANCE;
                    end
                end
                DRAIN: begin
                    // Flush WB so the HALT's own writeback is suppressed.
                    ctrl.memW   = 1'b1;
                    ctrl.memRST = 1'b1;
                    next_state  = HALTED;
                end
                HALTED: begin
                    next_state = HALTED;
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    assign pcWEN    = ctrl.pcWEN;
    assign ifidW    = ctrl.ifidW;
    assign ifidRST  = ctrl.ifidRST;
    assign idexW    = ctrl.idexW;
    assign idexRST  = ctrl.idexRST;
    assign exmemW   = ctrl.exmemW;
    assign exmemRST = ctrl.exmemRST;
    assign memW     = ctrl.memW;
    assign memRST   = ctrl.memRST;

    assign count_en = !ctrl.pcWEN && ((state == RUN) || (state == DWAIT));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            halt        <= 1'b0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            if (state == DRAIN) begin
                halt <= 1'b1;
            end
            if (count_en && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
// Directed bench for pipeline_sequencer: a table of single-cycle RUN-state
// decode vectors plus hand-written multi-cycle sequences (data wait, load-use,
// branch priority, halt drain, reset mid-sequence, counter saturation).
// Control vectors are packed {pcWEN, ifidW, ifidRST, idexW, idexRST,
// exmemW, exmemRST, memW, memRST}.
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, memdREN, memdWEN, memcuHALT, idexMemRead, exPCSrc;
    logic [4:0]  idexrt, ifidrs, ifidrt;
    logic        pcWEN, ifidW, ifidRST, idexW, idexRST;
    logic        exmemW, exmemRST, memW, memRST, halt;
    logic [15:0] stall_count;

    int tests = 0;
    int fails = 0;

    localparam logic [8:0] C_NORM   = 9'b1_10_10_10_10;
    localparam logic [8:0] C_FREEZE = 9'b0_00_00_00_00;
    localparam logic [8:0] C_RESET  = 9'b0_11_11_11_11;
    localparam logic [8:0] C_HALT   = 9'b0_11_11_11_10;
    localparam logic [8:0] C_BRANCH = 9'b1_11_11_10_10;
    localparam logic [8:0] C_LU     = 9'b0_00_11_10_10;
    localparam logic [8:0] C_IMISS  = 9'b0_11_10_10_10;
    localparam logic [8:0] C_DRAIN  = 9'b0_00_00_00_11;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       memdREN;
        logic       memdWEN;
        logic       memcuHALT;
        logic       idexMemRead;
        logic [4:0] idexrt;
        logic [4:0] ifidrs;
        logic [4:0] ifidrt;
        logic       exPCSrc;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    pipeline_sequencer #(.CNT_W(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .memdREN     (memdREN),
        .memdWEN     (memdWEN),
        .memcuHALT   (memcuHALT),
        .idexMemRead (idexMemRead),
        .idexrt      (idexrt),
        .ifidrs      (ifidrs),
        .ifidrt      (ifidrt),
        .exPCSrc     (exPCSrc),
        .pcWEN       (pcWEN),
        .ifidW       (ifidW),
        .ifidRST     (ifidRST),
        .idexW       (idexW),
        .idexRST     (idexRST),
        .exmemW      (exmemW),
        .exmemRST    (exmemRST),
        .memW        (memW),
        .memRST      (memRST),
        .halt        (halt),
        .stall_count (stall_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] ctrl_now();
        return {pcWEN, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memW, memRST};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are then driven / outputs sampled 1ns after.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        ihit = 1'b1; dhit = 1'b0; memdREN = 1'b0; memdWEN = 1'b0;
        memcuHALT = 1'b0; idexMemRead = 1'b0; exPCSrc = 1'b0;
        idexrt = 5'd0; ifidrs = 5'd0; ifidrt = 5'd0;
    endtask

    task automatic reset_cycle();
        RST = 1'b1;
        set_idle();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        // ihit dhit rd wr halt ld  rt     rs     rt(id) br  expected
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,C_NORM});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,C_FREEZE});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,C_FREEZE});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,C_NORM});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,C_HALT});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b1,C_FREEZE});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd8, 5'd8, 5'd0, 1'b1,C_BRANCH});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd8, 5'd8, 5'd0, 1'b0,C_LU});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd5, 5'd1, 5'd5, 1'b0,C_LU});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd0, 5'd0, 5'd0, 1'b0,C_NORM});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd8, 5'd8, 5'd8, 1'b0,C_NORM});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,C_IMISS});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd3, 5'd3, 5'd3, 1'b0,C_LU});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b1,C_HALT});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd9, 5'd8, 5'd7, 1'b0,C_NORM});

        // Reset held two cycles, then release.
        RST = 1'b1;
        set_idle();
        #1;
        check("reset_ctrl", 32'(ctrl_now()), 32'(C_RESET));
        tick();
        tick();
        check("reset_halt", 32'(halt), 32'd0);
        check("reset_count", 32'(stall_count), 32'd0);
        RST = 1'b0;
        #1;
        check("release_ctrl", 32'(ctrl_now()), 32'(C_NORM));

        // RUN-state decode table.
        for (int i = 0; i < vecs.size(); i++) begin
            reset_cycle();
            ihit = vecs[i].ihit; dhit = vecs[i].dhit;
            memdREN = vecs[i].memdREN; memdWEN = vecs[i].memdWEN;
            memcuHALT = vecs[i].memcuHALT; idexMemRead = vecs[i].idexMemRead;
            idexrt = vecs[i].idexrt; ifidrs = vecs[i].ifidrs; ifidrt = vecs[i].ifidrt;
            exPCSrc = vecs[i].exPCSrc;
            #1;
            check($sformatf("vec%0d", i), 32'(ctrl_now()), 32'(vecs[i].exp));
        end

        // Data miss for three cycles, then hit.
        reset_cycle();
        memdREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("dwait_c%0d", i + 1), 32'(ctrl_now()), 32'(C_FREEZE));
            tick();
        end
        dhit = 1'b1;
        #1;
        check("dwait_resolve", 32'(ctrl_now()), 32'(C_NORM));
        tick();
        set_idle();
        check("dwait_count", 32'(stall_count), 32'd3);

        // Miss resolving in the same cycle as a taken branch.
        reset_cycle();
        memdWEN = 1'b1;
        tick();
        dhit = 1'b1; exPCSrc = 1'b1; ihit = 1'b0;
        #1;
        check("dwait_branch", 32'(ctrl_now()), 32'(C_BRANCH));
        tick();
        set_idle();
        #1;
        check("dwait_back_run", 32'(ctrl_now()), 32'(C_NORM));
        check("dwait_branch_cnt", 32'(stall_count), 32'd1);

        // Load-use lasts one cycle; the bubble in EX clears it.
        reset_cycle();
        idexMemRead = 1'b1; idexrt = 5'd8; ifidrs = 5'd8;
        #1;
        check("lu_stall", 32'(ctrl_now()), 32'(C_LU));
        tick();
        idexMemRead = 1'b0;
        #1;
        check("lu_next", 32'(ctrl_now()), 32'(C_NORM));
        tick();
        check("lu_count", 32'(stall_count), 32'd1);

        reset_cycle();
        idexMemRead = 1'b1; idexrt = 5'd0; ifidrs = 5'd0;
        #1;
        check("lu_r0", 32'(ctrl_now()), 32'(C_NORM));
        tick();
        check("lu_r0_count", 32'(stall_count), 32'd0);

        // Branch with load-use and fetch miss: no stall counted.
        reset_cycle();
        exPCSrc = 1'b1; idexMemRead = 1'b1; idexrt = 5'd8; ifidrs = 5'd8; ihit = 1'b0;
        #1;
        check("br_prio", 32'(ctrl_now()), 32'(C_BRANCH));
        tick();
        check("br_count", 32'(stall_count), 32'd0);

        // Halt drain.
        reset_cycle();
        memcuHALT = 1'b1;
        #1;
        check("halt_n", 32'(ctrl_now()), 32'(C_HALT));
        tick();
        set_idle();
        #1;
        check("halt_drain", 32'(ctrl_now()), 32'(C_DRAIN));
        check("halt_drain_flag", 32'(halt), 32'd0);
        tick();
        ihit = 1'b0; exPCSrc = 1'b1; memdREN = 1'b1; memcuHALT = 1'b1;
        #1;
        check("halted_flag", 32'(halt), 32'd1);
        check("halted_ctrl", 32'(ctrl_now()), 32'(C_FREEZE));
        tick();
        tick();
        check("halted_sticky", 32'(halt), 32'd1);
        check("halted_ctrl2", 32'(ctrl_now()), 32'(C_FREEZE));
        check("halted_count", 32'(stall_count), 32'd1);
        reset_cycle();
        #1;
        check("halt_cleared", 32'(halt), 32'd0);
        check("halt_clr_ctrl", 32'(ctrl_now()), 32'(C_NORM));

        // Reset while in DWAIT returns to RUN.
        reset_cycle();
        memdREN = 1'b1;
        tick();
        RST = 1'b1;
        #1;
        check("rst_dwait_ctrl", 32'(ctrl_now()), 32'(C_RESET));
        tick();
        RST = 1'b0;
        set_idle();
        #1;
        check("rst_dwait_run", 32'(ctrl_now()), 32'(C_NORM));

        // Reset while in DRAIN: no halt.
        reset_cycle();
        memcuHALT = 1'b1;
        tick();
        RST = 1'b1;
        set_idle();
        tick();
        RST = 1'b0;
        #1;
        check("rst_drain_ctrl", 32'(ctrl_now()), 32'(C_NORM));
        tick();
        check("rst_drain_halt", 32'(halt), 32'd0);

        // Counter saturation.
        reset_cycle();
        ihit = 1'b0;
        repeat (65535) tick();
        check("sat_reach", 32'(stall_count), 32'd65535);
        repeat (3) tick();
        check("sat_hold", 32'(stall_count), 32'd65535);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
